ccu_bus_arbiter: RTL

Round-robin arbiter and coherence sequencer for the shared CCU path between N L1 cache controllers and the next memory level. It grants one core's miss or write-upgrade request at a time and broadcasts a snoop to all other cores. It collects their snoop responses, fetches the word from a snooper or from memory, writes back dirty snooped data, and returns the word plus the requester's new MESI state with a one-cycle ready pulse.

---
 rtl/ccu_pkg.sv | 32 +++
 rtl/ccu_bus_arbiter_rr.sv | 58 +++++
 rtl/ccu_bus_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ccu_pkg.sv
// ccu_pkg: shared definitions for the CCU path. The bus arbiter and the
// L1 cache controllers both import this package.
//   mesi_t   : shared MESI line-state encoding (M=00, E=01, S=10, I=11)
//   state_t  : bus arbiter sequencer states
//   ADDR_W / DATA_W : word address and data widths
//   next_idx : modulo increment used for the round-robin pointer
package ccu_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        MESI_M = 2'b00,
        MESI_E = 2'b01,
        MESI_S = 2'b10,
        MESI_I = 2'b11
    } mesi_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNOOP,
        ST_WB,
        ST_FETCH,
        ST_RESP
    } state_t;

    // Index after idx, wrapping from n-1 back to 0.
    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ccu_bus_arbiter_rr.sv
// rr_arbiter: N-way round-robin priority picker.
// The select is purely combinational: the first requester at or after the
// stored pointer wins, wrapping modulo N. The pointer only moves on an
// accept strobe, and then to the accepted index plus one.
//   clk, rst        : clock, asynchronous active-high reset (pointer -> 0)
//   i_req           : per-requester request vector
//   i_accept        : strobe, advance pointer past i_accept_idx
//   i_accept_idx    : index of the requester that was served
//   o_valid         : at least one request is present
//   o_grant / o_idx : one-hot winner and its binary index
module rr_arbiter
    import ccu_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     i_req,
    input  logic             i_accept,
    input  logic [IDX_W-1:0] i_accept_idx,
    output logic             o_valid,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W-1:0] r_ptr;

    // Walk the offsets from farthest to nearest so that the requester
    // closest to the pointer is the one left standing at the end.
    always_comb begin
        int k;
        logic [N-1:0] sh;
        k       = 0;
        sh      = '0;
        o_valid = 1'b0;
        o_grant = '0;
        o_idx   = '0;
        for (int off = N - 1; off >= 0; off--) begin
            k  = (int'(r_ptr) + off) % N;
            sh = i_req >> k;
            if (sh[0]) begin
                o_valid = 1'b1;
                o_grant = N'(1) << k;
                o_idx   = IDX_W'(k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_accept) begin
            r_ptr <= IDX_W'(next_idx(int'(i_accept_idx), N));
        end
    end

endmodule

// File: rtl/ccu_bus_arbiter.sv
// ccu_bus_arbiter: round-robin arbiter and coherence sequencer for the
// shared CCU path between N L1 controllers and the next memory level.
// One request is served at a time: snoop all other cores, optionally
// write back a dirty snooped word, optionally fetch from memory, then
// pulse ccu_ready to the owner with the word and its new MESI state.
//   clk, rst                 : clock, asynchronous active-high reset
//   i_req/i_req_wr/i_req_addr: per-core request level, RFO flag, address
//   o_grant                  : one-hot owner, 0 when idle
//   o_snoop_req/addr/new_state : snoop broadcast to non-owners
//   i_snoop_hit/dirty/data   : snooper responses, valid SNOOP_LAT cycles in
//   o_mem_req/we/addr/wdata, i_mem_ack/rdata : next-level memory port
//   o_ccu_ready/data/state   : completion pulse, word and MESI state
module ccu_bus_arbiter
    import ccu_pkg::*;
#(
    parameter int N_CORES   = 4,
    parameter int SNOOP_LAT = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_CORES-1:0]          i_req,
    input  logic [N_CORES-1:0]          i_req_wr,
    input  logic [N_CORES*ADDR_W-1:0]   i_req_addr,
    output logic [N_CORES-1:0]          o_grant,
    output logic [N_CORES-1:0]          o_snoop_req,
    output logic [ADDR_W-1:0]           o_snoop_addr,
    output logic [1:0]                  o_snoop_new_state,
    input  logic [N_CORES-1:0]          i_snoop_hit,
    input  logic [N_CORES-1:0]          i_snoop_dirty,
    input  logic [N_CORES*DATA_W-1:0]   i_snoop_data,
    output logic                        o_mem_req,
    output logic                        o_mem_we,
    output logic [ADDR_W-1:0]           o_mem_addr,
    output logic [DATA_W-1:0]           o_mem_wdata,
    input  logic                        i_mem_ack,
    input  logic [DATA_W-1:0]           i_mem_rdata,
    output logic [N_CORES-1:0]          o_ccu_ready,
    output logic [DATA_W-1:0]           o_ccu_data,
    output logic [1:0]                  o_ccu_state
);

    localparam int IDX_W = $clog2(N_CORES);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [N_CORES-1:0]      r_grant;
    logic [IDX_W-1:0]        r_owner;
    logic [ADDR_W-1:0]       r_addr;
    logic                    r_wr;
    logic [2:0]              r_cnt;
    logic                    r_hit_any;
    logic [DATA_W-1:0]       r_data;

    logic                    w_arb_valid;
    logic [N_CORES-1:0]      w_arb_grant;
    logic [IDX_W-1:0]        w_arb_idx;
    logic                    w_accept;
    logic [N_CORES*ADDR_W-1:0] w_addr_sh;
    logic [N_CORES-1:0]      w_wr_sh;
    logic [ADDR_W-1:0]       w_req_addr;
    logic                    w_req_wr;
    logic [N_CORES-1:0]      w_hit_mask;
    logic [N_CORES-1:0]      w_dirty_mask;
    logic [DATA_W-1:0]       w_dirty_data;
    logic [DATA_W-1:0]       w_hit_data;
    logic                    w_snoop_last;

    rr_arbiter #(
        .N     (N_CORES),
        .IDX_W (IDX_W)
    ) u_rr (
        .clk          (clk),
        .rst          (rst),
        .i_req        (i_req),
        .i_accept     (w_accept),
        .i_accept_idx (r_owner),
        .o_valid      (w_arb_valid),
        .o_grant      (w_arb_grant),
        .o_idx        (w_arb_idx)
    );

    // Winner's address and write flag, picked by shifting the packed vectors.
    assign w_addr_sh  = i_req_addr >> (int'(w_arb_idx) * ADDR_W);
    assign w_req_addr = w_addr_sh[ADDR_W-1:0];
    assign w_wr_sh    = i_req_wr >> w_arb_idx;
    assign w_req_wr   = w_wr_sh[0];

    // The owner never snoops itself, so its own responses are masked off.
    assign w_hit_mask   = i_snoop_hit & ~r_grant;
    assign w_dirty_mask = i_snoop_dirty & ~r_grant;
    assign w_snoop_last = (r_cnt == 3'(SNOOP_LAT - 1));

    // Lowest-index dirty and lowest-index hit snooper data; descending scan
    // so the lowest matching index is the final assignment.
    always_comb begin
        logic [N_CORES-1:0]        sh_d;
        logic [N_CORES-1:0]        sh_h;
        logic [N_CORES*DATA_W-1:0] dsh;
        sh_d         = '0;
        sh_h         = '0;
        dsh          = '0;
        w_dirty_data = '0;
        w_hit_data   = '0;
        for (int k = N_CORES - 1; k >= 0; k--) begin
            sh_d = w_dirty_mask >> k;
            sh_h = w_hit_mask >> k;
            dsh  = i_snoop_data >> (k * DATA_W);
            if (sh_d[0]) w_dirty_data = dsh[DATA_W-1:0];
            if (sh_h[0]) w_hit_data = dsh[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and all memory/response outputs; outputs are pure
    // functions of state so an async reset clears them immediately.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        o_snoop_req  = '0;
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        o_ccu_ready  = '0;
        o_ccu_data   = '0;
        o_ccu_state  = MESI_M;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) w_next_state = ST_SNOOP;
            end
            ST_SNOOP: begin
                o_snoop_req = ~r_grant;
                if (w_snoop_last) begin
                    if (|w_dirty_mask)    w_next_state = ST_WB;
                    else if (|w_hit_mask) w_next_state = ST_RESP;
                    else                  w_next_state = ST_FETCH;
                end
            end
            ST_WB: begin
                o_mem_req   = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = r_addr;
                o_mem_wdata = r_data;
                if (i_mem_ack) w_next_state = ST_RESP;
            end
            ST_FETCH: begin
                o_mem_req  = 1'b1;
                o_mem_addr = r_addr;
                if (i_mem_ack) w_next_state = ST_RESP;
            end
            ST_RESP: begin
                o_ccu_ready  = r_grant;
                o_ccu_data   = r_data;
                o_ccu_state  = r_wr ? MESI_M : (r_hit_any ? MESI_S : MESI_E);
                w_accept     = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Transaction latches: owner context on accept, snoop summary on the
    // last snoop cycle, memory data on a fetch acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant   <= '0;
            r_owner   <= '0;
            r_addr    <= '0;
            r_wr      <= 1'b0;
            r_cnt     <= '0;
            r_hit_any <= 1'b0;
            r_data    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_valid) begin
                        r_grant   <= w_arb_grant;
                        r_owner   <= w_arb_idx;
                        r_addr    <= w_req_addr;
                        r_wr      <= w_req_wr;
                        r_cnt     <= '0;
                        r_hit_any <= 1'b0;
                    end
                end
                ST_SNOOP: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (w_snoop_last) begin
                        r_hit_any <= |w_hit_mask;
                        r_data    <= (|w_dirty_mask) ? w_dirty_data : w_hit_data;
                    end
                end
                ST_FETCH: begin
                    if (i_mem_ack) r_data <= i_mem_rdata;
                end
                ST_RESP: begin
                    r_grant <= '0;
                end
                default: ;
            endcase
        end
    end

    assign o_grant           = r_grant;
    assign o_snoop_addr      = r_addr;
    assign o_snoop_new_state = r_wr ? MESI_I : MESI_S;

endmodule
